// File: rtl/acc_c_arbiter.sv
// ============================================================================
// Module   : acc_c_arbiter
// Brief    : Round-robin arbiter sharing one accelerator among NumReq offloading
//            requesters; registered request path, combinational response routing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_c_arbiter #(
  parameter int NumReq    = 2,
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  // Requester-side request channel
  input  logic [NumReq*AddrWidth-1:0]   slv_q_addr_i,
  input  logic [NumReq*32-1:0]          slv_q_instr_data_i,
  input  logic [NumReq*2*DataWidth-1:0] slv_q_rs_i,
  input  logic [NumReq*DataWidth-1:0]   slv_q_hart_id_i,
  input  logic [NumReq-1:0]             slv_q_valid_i,
  output logic [NumReq-1:0]             slv_q_ready_o,
  // Requester-side response channel
  output logic [DataWidth-1:0]          slv_p_data_o,
  output logic [DataWidth-1:0]          slv_p_hart_id_o,
  output logic [4:0]                    slv_p_rd_o,
  output logic                          slv_p_error_o,
  output logic [NumReq-1:0]             slv_p_valid_o,
  input  logic [NumReq-1:0]             slv_p_ready_i,
  // Accelerator-side request channel
  output logic [AddrWidth-1:0]          mst_q_addr_o,
  output logic [31:0]                   mst_q_instr_data_o,
  output logic [2*DataWidth-1:0]        mst_q_rs_o,
  output logic [DataWidth-1:0]          mst_q_hart_id_o,
  output logic                          mst_q_valid_o,
  input  logic                          mst_q_ready_i,
  // Accelerator-side response channel
  input  logic [DataWidth-1:0]          mst_p_data_i,
  input  logic [DataWidth-1:0]          mst_p_hart_id_i,
  input  logic [4:0]                    mst_p_rd_i,
  input  logic                          mst_p_error_i,
  input  logic                          mst_p_valid_i,
  output logic                          mst_p_ready_o,
  output logic                          route_err_o
);

  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic                   buf_full_q,  buf_full_d;
  logic [AddrWidth-1:0]   buf_addr_q,  buf_addr_d;
  logic [31:0]            buf_instr_q, buf_instr_d;
  logic [2*DataWidth-1:0] buf_rs_q,    buf_rs_d;
  logic [DataWidth-1:0]   buf_hart_q,  buf_hart_d;
  logic [IdxW-1:0]        rr_ptr_q,    rr_ptr_d;
  logic                   route_err_q, route_err_d;

  logic                   gnt_found;
  logic [IdxW-1:0]        gnt_idx;
  logic [IdxW:0]          cand;
  logic                   can_load;
  logic                   up_hs;
  logic                   down_hs;
  logic [AddrWidth-1:0]   sel_addr;
  logic [31:0]            sel_instr;
  logic [2*DataWidth-1:0] sel_rs;
  logic [DataWidth-1:0]   sel_hart;

  logic [IdxW-1:0]        p_idx;
  logic                   p_in_range;
  logic                   p_ready_sel;

  // Search starts at rr_ptr and wraps; cand is one bit wider so the sum never overflows.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NumReq; k++) begin
      cand = {1'b0, rr_ptr_q} + (IdxW+1)'(k);
      if (cand >= (IdxW+1)'(NumReq)) begin
        cand = cand - (IdxW+1)'(NumReq);
      end
      if (!gnt_found && slv_q_valid_i[cand[IdxW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IdxW-1:0];
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_instr = '0;
    sel_rs    = '0;
    sel_hart  = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (gnt_idx == IdxW'(i)) begin
        sel_addr  = slv_q_addr_i[i*AddrWidth +: AddrWidth];
        sel_instr = slv_q_instr_data_i[i*32 +: 32];
        sel_rs    = slv_q_rs_i[i*2*DataWidth +: 2*DataWidth];
        sel_hart  = slv_q_hart_id_i[i*DataWidth +: DataWidth];
      end
    end
  end

  assign down_hs  = buf_full_q && mst_q_ready_i;
  assign can_load = !buf_full_q || mst_q_ready_i;
  assign up_hs    = gnt_found && can_load && rst_ni;

  // rst_ni gating keeps requesters stalled while the async reset is held.
  always_comb begin
    slv_q_ready_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      slv_q_ready_o[i] = up_hs && (gnt_idx == IdxW'(i));
    end
  end

  always_comb begin
    buf_full_d  = buf_full_q;
    buf_addr_d  = buf_addr_q;
    buf_instr_d = buf_instr_q;
    buf_rs_d    = buf_rs_q;
    buf_hart_d  = buf_hart_q;
    rr_ptr_d    = rr_ptr_q;
    if (up_hs) begin
      buf_full_d  = 1'b1;
      buf_addr_d  = sel_addr;
      buf_instr_d = sel_instr;
      buf_rs_d    = sel_rs;
      buf_hart_d  = sel_hart;
      rr_ptr_d    = (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + IdxW'(1);
    end else if (down_hs) begin
      buf_full_d  = 1'b0;
    end
  end

  assign p_idx      = mst_p_hart_id_i[IdxW-1:0];
  assign p_in_range = mst_p_hart_id_i < DataWidth'(NumReq);

  always_comb begin
    slv_p_valid_o = '0;
    p_ready_sel   = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (p_idx == IdxW'(i)) begin
        slv_p_valid_o[i] = mst_p_valid_i && p_in_range;
        p_ready_sel      = slv_p_ready_i[i];
      end
    end
  end

  // Misrouted responses are accepted and dropped so the accelerator never stalls.
  assign mst_p_ready_o = p_in_range ? p_ready_sel : 1'b1;
  assign route_err_d   = mst_p_valid_i && !p_in_range;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_full_q  <= 1'b0;
      buf_addr_q  <= '0;
      buf_instr_q <= '0;
      buf_rs_q    <= '0;
      buf_hart_q  <= '0;
      rr_ptr_q    <= '0;
      route_err_q <= 1'b0;
    end else begin
      buf_full_q  <= buf_full_d;
      buf_addr_q  <= buf_addr_d;
      buf_instr_q <= buf_instr_d;
      buf_rs_q    <= buf_rs_d;
      buf_hart_q  <= buf_hart_d;
      rr_ptr_q    <= rr_ptr_d;
      route_err_q <= route_err_d;
    end
  end

  assign mst_q_valid_o      = buf_full_q;
  assign mst_q_addr_o       = buf_addr_q;
  assign mst_q_instr_data_o = buf_instr_q;
  assign mst_q_rs_o         = buf_rs_q;
  assign mst_q_hart_id_o    = buf_hart_q;

  assign slv_p_data_o    = mst_p_data_i;
  assign slv_p_hart_id_o = mst_p_hart_id_i;
  assign slv_p_rd_o      = mst_p_rd_i;
  assign slv_p_error_o   = mst_p_error_i;
  assign route_err_o     = route_err_q;

endmodule

`default_nettype wire

// File: tb/tb_acc_c_arbiter.sv
// ============================================================================
// Module   : tb_acc_c_arbiter
// Brief    : Self-checking bench for acc_c_arbiter with a request scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_acc_c_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N*AW-1:0]   slv_q_addr_i = '0;
  logic [N*32-1:0]   slv_q_instr_data_i = '0;
  logic [N*2*DW-1:0] slv_q_rs_i = '0;
  logic [N*DW-1:0]   slv_q_hart_id_i = {32'd1, 32'd0};
  logic [N-1:0]      slv_q_valid_i = '0;
  logic [N-1:0]      slv_q_ready_o;
  logic [DW-1:0]     slv_p_data_o;
  logic [DW-1:0]     slv_p_hart_id_o;
  logic [4:0]        slv_p_rd_o;
  logic              slv_p_error_o;
  logic [N-1:0]      slv_p_valid_o;
  logic [N-1:0]      slv_p_ready_i = '0;
  logic [AW-1:0]     mst_q_addr_o;
  logic [31:0]       mst_q_instr_data_o;
  logic [2*DW-1:0]   mst_q_rs_o;
  logic [DW-1:0]     mst_q_hart_id_o;
  logic              mst_q_valid_o;
  logic              mst_q_ready_i = 1'b0;
  logic [DW-1:0]     mst_p_data_i = '0;
  logic [DW-1:0]     mst_p_hart_id_i = '0;
  logic [4:0]        mst_p_rd_i = '0;
  logic              mst_p_error_i = 1'b0;
  logic              mst_p_valid_i = 1'b0;
  logic              mst_p_ready_o;
  logic              route_err_o;

  always #5 clk = ~clk;

  acc_c_arbiter #(.NumReq(N), .DataWidth(DW), .AddrWidth(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_q_addr_i(slv_q_addr_i), .slv_q_instr_data_i(slv_q_instr_data_i),
    .slv_q_rs_i(slv_q_rs_i), .slv_q_hart_id_i(slv_q_hart_id_i),
    .slv_q_valid_i(slv_q_valid_i), .slv_q_ready_o(slv_q_ready_o),
    .slv_p_data_o(slv_p_data_o), .slv_p_hart_id_o(slv_p_hart_id_o),
    .slv_p_rd_o(slv_p_rd_o), .slv_p_error_o(slv_p_error_o),
    .slv_p_valid_o(slv_p_valid_o), .slv_p_ready_i(slv_p_ready_i),
    .mst_q_addr_o(mst_q_addr_o), .mst_q_instr_data_o(mst_q_instr_data_o),
    .mst_q_rs_o(mst_q_rs_o), .mst_q_hart_id_o(mst_q_hart_id_o),
    .mst_q_valid_o(mst_q_valid_o), .mst_q_ready_i(mst_q_ready_i),
    .mst_p_data_i(mst_p_data_i), .mst_p_hart_id_i(mst_p_hart_id_i),
    .mst_p_rd_i(mst_p_rd_i), .mst_p_error_i(mst_p_error_i),
    .mst_p_valid_i(mst_p_valid_i), .mst_p_ready_o(mst_p_ready_o),
    .route_err_o(route_err_o)
  );

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [31:0]     instr;
    logic [2*DW-1:0] rs;
    logic [DW-1:0]   hart;
  } req_t;

  req_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   full_m = 1'b0;
  int   rr_m   = 0;

  // Reference model of the arbiter: predicts grants, pushes accepted requests,
  // and checks the output register against the oldest expected entry.
  always @(negedge clk) begin : scoreboard
    int         g;
    int         c;
    bit         can;
    logic [N-1:0] exp_rdy;
    req_t       e;
    req_t       got;
    got.addr  = mst_q_addr_o;
    got.instr = mst_q_instr_data_o;
    got.rs    = mst_q_rs_o;
    got.hart  = mst_q_hart_id_o;
    if (!rst_n) begin
      full_m = 1'b0;
      rr_m   = 0;
      exp_q.delete();
    end else begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        c = (rr_m + k) % N;
        if (g < 0 && slv_q_valid_i[c]) g = c;
      end
      can = !full_m || mst_q_ready_i;
      exp_rdy = '0;
      if (g >= 0 && can) exp_rdy[g] = 1'b1;
      checks++;
      if (slv_q_ready_o !== exp_rdy) begin
        errors++;
        $display("FAIL sb_ready t=%0t got %b exp %b", $time, slv_q_ready_o, exp_rdy);
      end
      checks++;
      if (mst_q_valid_o !== full_m) begin
        errors++;
        $display("FAIL sb_valid t=%0t got %b exp %b", $time, mst_q_valid_o, full_m);
      end
      if (full_m) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_empty t=%0t got queue empty exp an entry", $time);
        end else begin
          if (got !== exp_q[0]) begin
            errors++;
            $display("FAIL sb_req t=%0t got %h exp %h", $time, got, exp_q[0]);
          end
          if (mst_q_ready_i) void'(exp_q.pop_front());
        end
      end
      if (g >= 0 && can) begin
        e.addr  = slv_q_addr_i[g*AW +: AW];
        e.instr = slv_q_instr_data_i[g*32 +: 32];
        e.rs    = slv_q_rs_i[g*2*DW +: 2*DW];
        e.hart  = slv_q_hart_id_i[g*DW +: DW];
        exp_q.push_back(e);
        rr_m = (g + 1) % N;
      end
      full_m = (g >= 0 && can) || (full_m && !mst_q_ready_i);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_fields();
    for (int i = 0; i < N; i++) begin
      slv_q_addr_i[i*AW +: AW]         = $urandom;
      slv_q_instr_data_i[i*32 +: 32]   = $urandom;
      slv_q_rs_i[i*2*DW +: 2*DW]       = {$urandom, $urandom};
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    slv_q_valid_i = 2'b11;
    mst_q_ready_i = 1'b1;
    rand_fields();
    @(negedge clk);
    checks++;
    if (slv_q_ready_o !== 2'b00) begin
      errors++; $display("FAIL rst_ready got %b exp 00", slv_q_ready_o);
    end
    checks++;
    if (mst_q_valid_o !== 1'b0) begin
      errors++; $display("FAIL rst_valid got %b exp 0", mst_q_valid_o);
    end
    checks++;
    if (route_err_o !== 1'b0) begin
      errors++; $display("FAIL rst_route_err got %b exp 0", route_err_o);
    end
    checks++;
    if (mst_q_addr_o !== '0 || mst_q_instr_data_o !== '0) begin
      errors++; $display("FAIL rst_buf got %h/%h exp 0/0", mst_q_addr_o, mst_q_instr_data_o);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_alternate();
    for (int k = 0; k < 8; k++) begin
      rand_fields();
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (slv_q_ready_o !== 2'b01) begin
          errors++; $display("FAIL alt_first_grant got %b exp 01", slv_q_ready_o);
        end
      end else begin
        checks++;
        if (mst_q_hart_id_o !== DW'((k - 1) % 2)) begin
          errors++; $display("FAIL alt_hart k=%0d got %0d exp %0d", k, mst_q_hart_id_o, (k - 1) % 2);
        end
      end
      tick();
    end
    slv_q_valid_i = '0;
    tick(); tick();
  endtask

  task automatic test_single();
    mst_q_ready_i = 1'b1;
    rand_fields();
    slv_q_instr_data_i[32 +: 32] = 32'h0000_0033;
    slv_q_valid_i = 2'b10;
    @(negedge clk);
    checks++;
    if (slv_q_ready_o !== 2'b10) begin
      errors++; $display("FAIL single_ready got %b exp 10", slv_q_ready_o);
    end
    tick();
    slv_q_valid_i = 2'b00;
    @(negedge clk);
    checks++;
    if (mst_q_instr_data_o !== 32'h33 || mst_q_valid_o !== 1'b1) begin
      errors++; $display("FAIL single_instr got %h/%b exp 33/1", mst_q_instr_data_o, mst_q_valid_o);
    end
    tick();
    slv_q_valid_i = 2'b11;
    @(negedge clk);
    checks++;
    if (slv_q_ready_o !== 2'b01) begin
      errors++; $display("FAIL single_rr_wrap got %b exp 01", slv_q_ready_o);
    end
    tick();
    slv_q_valid_i = 2'b00;
    tick(); tick();
  endtask

  task automatic test_backpressure();
    mst_q_ready_i = 1'b1;
    slv_q_valid_i = 2'b11;
    rand_fields();
    tick();
    mst_q_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rand_fields();
      @(negedge clk);
      checks++;
      if (slv_q_ready_o !== 2'b00 || mst_q_valid_o !== 1'b1) begin
        errors++; $display("FAIL bp_stall k=%0d got %b/%b exp 00/1", k, slv_q_ready_o, mst_q_valid_o);
      end
      tick();
    end
    mst_q_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (!$onehot(slv_q_ready_o)) begin
      errors++; $display("FAIL bp_reload got %b exp one-hot", slv_q_ready_o);
    end
    tick();
    slv_q_valid_i = 2'b00;
    @(negedge clk);
    checks++;
    if (mst_q_valid_o !== 1'b1) begin
      errors++; $display("FAIL bp_refilled got %b exp 1", mst_q_valid_o);
    end
    tick(); tick();
  endtask

  task automatic test_response();
    mst_p_valid_i   = 1'b1;
    mst_p_hart_id_i = 32'd1;
    mst_p_data_i    = 32'hCAFE_F00D;
    mst_p_rd_i      = 5'd17;
    mst_p_error_i   = 1'b1;
    slv_p_ready_i   = 2'b00;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) slv_p_ready_i = 2'b10;
      @(negedge clk);
      checks++;
      if (slv_p_valid_o !== 2'b10 || mst_p_ready_o !== (k == 3)) begin
        errors++; $display("FAIL resp k=%0d got %b/%b exp 10/%0d", k, slv_p_valid_o, mst_p_ready_o, k == 3);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (slv_p_data_o !== 32'hCAFE_F00D || slv_p_rd_o !== 5'd17 || slv_p_error_o !== 1'b1
        || slv_p_hart_id_o !== 32'd1) begin
      errors++; $display("FAIL resp_fields got %h/%0d/%b/%0d exp cafef00d/17/1/1",
                         slv_p_data_o, slv_p_rd_o, slv_p_error_o, slv_p_hart_id_o);
    end
    tick();
    mst_p_valid_i = 1'b0;
    slv_p_ready_i = 2'b00;
    tick();
  endtask

  task automatic test_route_err();
    mst_p_valid_i   = 1'b1;
    mst_p_hart_id_i = 32'd5;
    slv_p_ready_i   = 2'b00;
    @(negedge clk);
    checks++;
    if (slv_p_valid_o !== 2'b00 || mst_p_ready_o !== 1'b1 || route_err_o !== 1'b0) begin
      errors++; $display("FAIL route_drop got %b/%b/%b exp 00/1/0", slv_p_valid_o, mst_p_ready_o, route_err_o);
    end
    tick();
    mst_p_valid_i   = 1'b0;
    mst_p_hart_id_i = 32'd0;
    @(negedge clk);
    checks++;
    if (route_err_o !== 1'b1) begin
      errors++; $display("FAIL route_err_pulse got %b exp 1", route_err_o);
    end
    tick();
    mst_p_valid_i = 1'b1;
    slv_p_ready_i = 2'b01;
    @(negedge clk);
    checks++;
    if (route_err_o !== 1'b0 || slv_p_valid_o !== 2'b01 || mst_p_ready_o !== 1'b1) begin
      errors++; $display("FAIL route_err_clear got %b/%b/%b exp 0/01/1", route_err_o, slv_p_valid_o, mst_p_ready_o);
    end
    tick();
    mst_p_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (route_err_o !== 1'b0) begin
      errors++; $display("FAIL route_err_valid_hart got %b exp 0", route_err_o);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    mst_q_ready_i = 1'b0;
    slv_q_valid_i = 2'b11;
    rand_fields();
    tick();
    @(negedge clk);
    checks++;
    if (mst_q_valid_o !== 1'b1) begin
      errors++; $display("FAIL mid_full got %b exp 1", mst_q_valid_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mst_q_valid_o !== 1'b0 || slv_q_ready_o !== 2'b00) begin
      errors++; $display("FAIL mid_async got %b/%b exp 0/00", mst_q_valid_o, slv_q_ready_o);
    end
    tick(); tick();
    mst_q_ready_i = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (slv_q_ready_o !== 2'b01) begin
      errors++; $display("FAIL mid_restart got %b exp 01", slv_q_ready_o);
    end
    tick();
    slv_q_valid_i = 2'b00;
    @(negedge clk);
    checks++;
    if (mst_q_valid_o !== 1'b1 || mst_q_hart_id_o !== 32'd0) begin
      errors++; $display("FAIL mid_first got %b/%0d exp 1/0", mst_q_valid_o, mst_q_hart_id_o);
    end
    tick(); tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      rand_fields();
      slv_q_valid_i = N'($urandom_range(0, 3));
      mst_q_ready_i = ($urandom_range(0, 3) != 0);
      tick();
    end
    slv_q_valid_i = 2'b00;
    mst_q_ready_i = 1'b1;
    tick(); tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rand_drain got %0d entries exp 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_single();
    test_backpressure();
    test_response();
    test_route_err();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
